issue_select: RTL

ISSUE_SELECT -- requirements
Module: issue_select

---
 rtl/issue_select.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/issue_select.sv
// ----------------------------------------------------------------------------
// issue_select
//
// Picks one ready issue slot per cycle and stages its micro-op in a
// single-entry issue register that feeds register read.
//
// Selection rules:
//   - A slot is eligible when it requests and its branch mask misses i_brkill.
//   - The highest priority eligible slot wins.
//   - Equal priorities go to the first eligible slot found scanning upward
//     (circularly) from a round-robin pointer.
//   - The pointer moves to one past the winner after every grant.
//
// A grant is only issued when the issue register can take a new op. That is
// the case when the register is empty, when it is being accepted this cycle,
// or when the op it holds is being killed this cycle.
//
// Parameters:
//   NSLOT      number of issue slots (power of two, >= 2)
//   WIDTH_O    width of one slot micro-op word
//   WIDTH_PRY  width of one slot priority field
//   WIDTH_BRM  branch-mask width; mask lives in the top bits of each word
//
// Ports:
//   i_clk       clock, all state on rising edge
//   i_rst       synchronous active-high reset
//   i_request   per-slot ready-to-issue request
//   i_priority  per-slot priority, slot k at [k*WIDTH_PRY +: WIDTH_PRY]
//   i_rslot     per-slot micro-op, slot k at [k*WIDTH_O +: WIDTH_O]
//   i_brkill    branch mispredict kill vector, valid this cycle
//   i_ready     register-read stage accepts o_data this cycle
//   o_grant     one-hot (or zero) grant back to the slots, combinational
//   o_valid     issue register holds a live micro-op
//   o_data      issue register contents
// ----------------------------------------------------------------------------
module issue_select #(
    parameter int unsigned NSLOT     = 8,
    parameter int unsigned WIDTH_O   = 32,
    parameter int unsigned WIDTH_PRY = 2,
    parameter int unsigned WIDTH_BRM = 4
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic [NSLOT-1:0]           i_request,
    input  logic [NSLOT*WIDTH_PRY-1:0] i_priority,
    input  logic [NSLOT*WIDTH_O-1:0]   i_rslot,
    input  logic [WIDTH_BRM-1:0]       i_brkill,
    input  logic                       i_ready,
    output logic [NSLOT-1:0]           o_grant,
    output logic                       o_valid,
    output logic [WIDTH_O-1:0]         o_data
);

    localparam int unsigned PtrW = $clog2(NSLOT);

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic               valid_q, valid_d;
    logic [WIDTH_O-1:0] data_q, data_d;
    logic [PtrW-1:0]    rr_ptr_q, rr_ptr_d;

    // ------------------------------------------------------------------------
    // Unpack slot fields
    // ------------------------------------------------------------------------
    logic [WIDTH_PRY-1:0] slot_pri  [NSLOT];
    logic [WIDTH_O-1:0]   slot_word [NSLOT];
    logic [NSLOT-1:0]     eligible;

    always_comb begin
        for (int unsigned k = 0; k < NSLOT; k++) begin
            slot_pri[k]  = i_priority[k*WIDTH_PRY +: WIDTH_PRY];
            slot_word[k] = i_rslot[k*WIDTH_O +: WIDTH_O];
            eligible[k]  = i_request[k] &
                           ~|(slot_word[k][WIDTH_O-1 -: WIDTH_BRM] & i_brkill);
        end
    end

    // ------------------------------------------------------------------------
    // Issue register availability
    // ------------------------------------------------------------------------
    logic staged_killed;
    logic can_load;

    // A staged op hit by the kill vector is dropped, which frees the register
    // in the same cycle even though register read did not take it.
    assign staged_killed = valid_q & |(data_q[WIDTH_O-1 -: WIDTH_BRM] & i_brkill);
    assign can_load      = ~valid_q | i_ready | staged_killed;

    // ------------------------------------------------------------------------
    // Priority select with round-robin tie-break
    // ------------------------------------------------------------------------
    logic                 found;
    logic [PtrW-1:0]      best_idx;
    logic [WIDTH_PRY-1:0] best_pri;
    logic [PtrW-1:0]      scan_idx;

    // The scan visits slots in circular order starting at rr_ptr. Only a
    // strictly higher priority replaces the current pick, so the first slot
    // seen at the winning priority level keeps the grant.
    always_comb begin
        found    = 1'b0;
        best_idx = '0;
        best_pri = '0;
        scan_idx = '0;
        for (int unsigned i = 0; i < NSLOT; i++) begin
            // Index arithmetic wraps naturally because NSLOT is a power of two.
            scan_idx = rr_ptr_q + PtrW'(i);
            if (eligible[scan_idx] && (!found || (slot_pri[scan_idx] > best_pri))) begin
                found    = 1'b1;
                best_idx = scan_idx;
                best_pri = slot_pri[scan_idx];
            end
        end
    end

    logic grant_any;

    assign grant_any = found & can_load & ~i_rst;

    always_comb begin
        for (int unsigned k = 0; k < NSLOT; k++) begin
            o_grant[k] = grant_any && (best_idx == PtrW'(k));
        end
    end

    // ------------------------------------------------------------------------
    // Next state
    // ------------------------------------------------------------------------
    always_comb begin
        valid_d  = valid_q;
        data_d   = data_q;
        rr_ptr_d = rr_ptr_q;
        if (grant_any) begin
            // A grant covers plain loads, back-to-back issue under i_ready, and
            // replacement of a killed staged op.
            valid_d  = 1'b1;
            data_d   = slot_word[best_idx];
            rr_ptr_d = best_idx + PtrW'(1);
        end else if (can_load) begin
            // Register drained or killed with nothing to replace it; the data
            // is held as a don't-care.
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            valid_q  <= 1'b0;
            data_q   <= '0;
            rr_ptr_q <= '0;
        end else begin
            valid_q  <= valid_d;
            data_q   <= data_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    assign o_valid = valid_q;
    assign o_data  = data_q;

endmodule
